// File: rtl/serial_deserializer_pkg.sv
// Shared definitions for the serial deserializer: FSM state encoding,
// bit-order constants and the default word length.
package serial_deserializer_pkg;

    localparam int DEFAULT_WIDTH = 8;

    localparam logic DIR_MSB_FIRST = 1'b0;
    localparam logic DIR_LSB_FIRST = 1'b1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        HOLD  = 2'd2
    } state_t;

endpackage

// File: rtl/serial_deserializer_bit_counter.sv
// Counts accepted serial bits within a frame; flags the last bit of the word
// and wraps back to zero on it so the count never passes WIDTH-1.
module bit_counter
    import serial_deserializer_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    localparam int CW   = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic terminal
);

    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    logic [CW-1:0] count;

    assign terminal = enable && (count == LAST);

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            count <= '0;
        end else if (enable) begin
            count <= terminal ? '0 : count + CW'(1);
        end
    end

endmodule

// File: rtl/serial_deserializer.sv
// Serial-to-parallel converter with selectable bit order, valid/ready
// output handshake, back-to-back frame support and a sticky overrun flag.
module serial_deserializer
    import serial_deserializer_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             dir,
    input  logic             sin,
    input  logic             sin_valid,
    input  logic             data_ready,
    output logic [WIDTH-1:0] q_reg,
    output logic             data_valid,
    output logic             busy,
    output logic             overrun
);

    state_t           state;
    logic [WIDTH-1:0] sr;
    logic [WIDTH-1:0] next_sr;
    logic             dir_latched;
    logic             start_accept;
    logic             shift_en;
    logic             last_bit;

    assign busy       = (state == SHIFT);
    assign data_valid = (state == HOLD);
    assign shift_en   = busy && sin_valid;

    // A new frame may begin from IDLE, or from HOLD in the same cycle the word is consumed.
    assign start_accept = start && ((state == IDLE) || (data_valid && data_ready));

    always_comb begin
        next_sr = sr;
        if (dir_latched == DIR_LSB_FIRST) begin
            next_sr = {sin, sr[WIDTH-1:1]};
        end else begin
            next_sr = {sr[WIDTH-2:0], sin};
        end
    end

    bit_counter #(
        .WIDTH(WIDTH)
    ) u_bit_counter (
        .clk     (clk),
        .reset   (reset),
        .clear   (start_accept),
        .enable  (shift_en),
        .terminal(last_bit)
    );

    // The final bit goes straight into q_reg so the word is visible one cycle after it arrives.
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            sr          <= '0;
            q_reg       <= '0;
            overrun     <= 1'b0;
            dir_latched <= DIR_MSB_FIRST;
        end else begin
            if (shift_en) begin
                sr <= next_sr;
            end
            if (shift_en && last_bit) begin
                q_reg <= next_sr;
                state <= HOLD;
            end
            if (data_valid && sin_valid) begin
                overrun <= 1'b1;
            end
            if (start_accept) begin
                state       <= SHIFT;
                sr          <= '0;
                dir_latched <= dir;
                overrun     <= 1'b0;
            end else if (data_valid && data_ready) begin
                state <= IDLE;
            end
        end
    end

endmodule

// File: tb/tb_serial_deserializer.sv
// Self-checking bench for serial_deserializer: directed scenarios followed by
// randomized frames checked against a word-level reference model.
module tb_serial_deserializer;

    localparam int W = 8;

    logic         clk;
    logic         reset;
    logic         start;
    logic         dir;
    logic         sin;
    logic         sin_valid;
    logic         data_ready;
    logic [W-1:0] q_reg;
    logic         data_valid;
    logic         busy;
    logic         overrun;

    int check_count = 0;
    int pass_count  = 0;
    int fail_count  = 0;

    logic         hold_armed = 1'b0;
    logic [W-1:0] q_prev     = '0;

    serial_deserializer #(
        .WIDTH(W)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .dir       (dir),
        .sin       (sin),
        .sin_valid (sin_valid),
        .data_ready(data_ready),
        .q_reg     (q_reg),
        .data_valid(data_valid),
        .busy      (busy),
        .overrun   (overrun)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic check_output(input string tag, input logic [31:0] observed,
                                input logic [31:0] expected);
        check_count++;
        assert (observed === expected) pass_count++;
        else begin
            fail_count++;
            $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Outputs must never show valid and busy together, and q_reg must not move while a word waits.
    always @(negedge clk) begin
        check_output("valid_busy_exclusive", 32'(data_valid & busy), 32'd0);
        if (hold_armed) check_output("q_stable_in_hold", 32'(q_reg), 32'(q_prev));
        hold_armed = data_valid && !data_ready && !reset;
        q_prev     = q_reg;
    end

    task automatic apply_stimulus_start(input logic d);
        start = 1'b1;
        dir   = d;
        tick();
        start = 1'b0;
        dir   = 1'($urandom);
        check_output("start_busy", 32'(busy), 32'd1);
        check_output("start_valid", 32'(data_valid), 32'd0);
        check_output("start_overrun", 32'(overrun), 32'd0);
    endtask

    // Sends one word serially in the requested order; gap_pct is the chance of an idle cycle before each bit.
    task automatic apply_stimulus_word(input logic [W-1:0] word, input logic d, input int gap_pct);
        for (int i = 0; i < W; i++) begin
            if ($urandom_range(99) < gap_pct) begin
                sin_valid = 1'b0;
                sin       = 1'($urandom);
                tick();
                check_output("gap_no_valid", 32'(data_valid), 32'd0);
                check_output("gap_busy", 32'(busy), 32'd1);
            end
            sin       = d ? word[i] : word[W-1-i];
            sin_valid = 1'b1;
            tick();
            if (i < W - 1) begin
                check_output("no_early_valid", 32'(data_valid), 32'd0);
            end
        end
        sin_valid = 1'b0;
        check_output("word_valid", 32'(data_valid), 32'd1);
        check_output("word_not_busy", 32'(busy), 32'd0);
        check_output("word_value", 32'(q_reg), 32'(word));
    endtask

    task automatic apply_stimulus_consume(input logic next_start, input logic next_dir);
        data_ready = 1'b1;
        start      = next_start;
        dir        = next_dir;
        tick();
        data_ready = 1'b0;
        start      = 1'b0;
        dir        = 1'($urandom);
        check_output("consume_valid_drop", 32'(data_valid), 32'd0);
        check_output("consume_busy", 32'(busy), 32'(next_start));
    endtask

    initial begin
        logic [W-1:0] word;
        logic         d;
        logic         next_d;
        logic         b2b;
        logic         in_shift;
        logic         exp_ovr;
        int           waits;

        reset      = 1'b1;
        start      = 1'b0;
        dir        = 1'b0;
        sin        = 1'b0;
        sin_valid  = 1'b0;
        data_ready = 1'b0;
        tick();
        tick();
        reset = 1'b0;
        check_output("reset_q", 32'(q_reg), 32'd0);
        check_output("reset_valid", 32'(data_valid), 32'd0);
        check_output("reset_busy", 32'(busy), 32'd0);
        check_output("reset_overrun", 32'(overrun), 32'd0);

        // MSB-first 0xA5 on consecutive cycles
        apply_stimulus_start(1'b0);
        apply_stimulus_word(8'hA5, 1'b0, 0);
        apply_stimulus_consume(1'b0, 1'b0);

        // LSB-first 0x3C with an idle cycle before every bit
        apply_stimulus_start(1'b1);
        apply_stimulus_word(8'h3C, 1'b1, 100);
        apply_stimulus_consume(1'b0, 1'b0);

        // 0x81 held for 5 cycles with a stray bit in cycle 3 and an ignored start in cycle 4
        apply_stimulus_start(1'b0);
        apply_stimulus_word(8'h81, 1'b0, 0);
        for (int c = 1; c <= 5; c++) begin
            sin_valid  = (c == 3);
            start      = (c == 4);
            sin        = 1'($urandom);
            data_ready = 1'b0;
            tick();
            check_output("hold_q", 32'(q_reg), 32'h81);
            check_output("hold_valid", 32'(data_valid), 32'd1);
            check_output("hold_busy", 32'(busy), 32'd0);
            check_output("hold_overrun", 32'(overrun), (c >= 3) ? 32'd1 : 32'd0);
        end
        sin_valid = 1'b0;
        start     = 1'b0;
        apply_stimulus_consume(1'b0, 1'b0);
        check_output("overrun_sticky", 32'(overrun), 32'd1);

        // Reset in mid-frame, asserted together with start/sin_valid/data_ready
        apply_stimulus_start(1'b0);
        for (int i = 0; i < 4; i++) begin
            sin       = 1'(i % 2);
            sin_valid = 1'b1;
            tick();
        end
        reset      = 1'b1;
        start      = 1'b1;
        data_ready = 1'b1;
        tick();
        reset      = 1'b0;
        start      = 1'b0;
        sin_valid  = 1'b0;
        data_ready = 1'b0;
        check_output("midreset_q", 32'(q_reg), 32'd0);
        check_output("midreset_valid", 32'(data_valid), 32'd0);
        check_output("midreset_busy", 32'(busy), 32'd0);
        check_output("midreset_overrun", 32'(overrun), 32'd0);
        apply_stimulus_start(1'b0);
        apply_stimulus_word(8'hFF, 1'b0, 0);
        apply_stimulus_consume(1'b0, 1'b0);

        // Back-to-back: consume 0x5A while starting an LSB-first frame
        apply_stimulus_start(1'b0);
        apply_stimulus_word(8'h5A, 1'b0, 0);
        apply_stimulus_consume(1'b1, 1'b1);
        apply_stimulus_word(8'h12, 1'b1, 0);
        apply_stimulus_consume(1'b0, 1'b0);

        // Random frames: the model expects the sent word back and overrun = any bit seen while holding
        in_shift = 1'b0;
        next_d   = 1'($urandom);
        for (int f = 0; f < 24; f++) begin
            word    = W'($urandom);
            d       = next_d;
            exp_ovr = 1'b0;
            if (!in_shift) apply_stimulus_start(d);
            apply_stimulus_word(word, d, 30);
            check_output("rand_overrun_after_frame", 32'(overrun), 32'(exp_ovr));
            waits = $urandom_range(3);
            for (int k = 0; k < waits; k++) begin
                sin_valid = 1'($urandom);
                sin       = 1'($urandom);
                tick();
                exp_ovr = exp_ovr | sin_valid;
                check_output("rand_hold_q", 32'(q_reg), 32'(word));
                check_output("rand_hold_overrun", 32'(overrun), 32'(exp_ovr));
            end
            sin_valid = 1'b0;
            next_d    = 1'($urandom);
            b2b       = 1'($urandom);
            apply_stimulus_consume(b2b, next_d);
            check_output("rand_overrun_after_consume", 32'(overrun), b2b ? 32'd0 : 32'(exp_ovr));
            in_shift = b2b;
        end

        tick();
        $display("[TB] %0d/%0d checks passed", pass_count, check_count);
        $finish;
    end

endmodule
